// File: rtl/rfft_pkg.sv
// Shared constants, FSM state type and stage pairing mask for the 256-point FFT sequencer.
package rfft_pkg;
  localparam int ADDR_W = 6;
  localparam int STAGES = 7;
  localparam int LIMIT  = 63;
  localparam int VALID  = 2;
  localparam int CNT_W  = 7;
  localparam int STG_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rfft_state_e;

  // Stage s pairs word i with word i ^ mask, where mask has the top s address bits set.
  function automatic logic [ADDR_W-1:0] stage_mask(input logic [STG_W-1:0] s);
    logic [ADDR_W-1:0] ones;
    ones = '1;
    return ~(ones >> s);
  endfunction
endpackage

// File: rtl/rfft_ctrl_if.sv
// Start/busy/done handshake plus bank, twiddle and PE control bundle of rfft_ctrl.
// Defining RFFT_CTRL_ERR_EN adds the start_err flag.
interface rfft_ctrl_if;
  import rfft_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic [STG_W-1:0]  stage;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic              we;
  logic [ADDR_W-1:0] tf_addr;
  logic              in_swap;
  logic              out_swap;
  logic              bypass_n;

`ifdef RFFT_CTRL_ERR_EN
  logic              start_err;

  modport master (
    output start,
    input  busy, done, stage, rd_addr0, rd_addr1, wr_addr0, wr_addr1, we,
           tf_addr, in_swap, out_swap, bypass_n, start_err
  );

  modport slave (
    input  start,
    output busy, done, stage, rd_addr0, rd_addr1, wr_addr0, wr_addr1, we,
           tf_addr, in_swap, out_swap, bypass_n, start_err
  );
`else
  modport master (
    output start,
    input  busy, done, stage, rd_addr0, rd_addr1, wr_addr0, wr_addr1, we,
           tf_addr, in_swap, out_swap, bypass_n
  );

  modport slave (
    input  start,
    output busy, done, stage, rd_addr0, rd_addr1, wr_addr0, wr_addr1, we,
           tf_addr, in_swap, out_swap, bypass_n
  );
`endif
endinterface

// File: rtl/rfft_addr_gen.sv
// Combinational map from (stage, rd_cnt, wr_cnt) to bank addresses, twiddle address,
// crossbar swap selects and PE bypass control.
module rfft_addr_gen
  import rfft_pkg::*;
(
  input  logic              run,
  input  logic [STG_W-1:0]  stage,
  input  logic [CNT_W-1:0]  rd_cnt,
  input  logic [ADDR_W-1:0] wr_cnt,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic [ADDR_W-1:0] tf_addr,
  output logic              in_swap,
  output logic              out_swap,
  output logic              bypass_n
);
  localparam logic [STG_W-1:0] LAST_STG   = STG_W'(STAGES - 1);
  localparam logic [STG_W-1:0] LAST_OSWAP = STG_W'(ADDR_W - 1);

  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] rd_w;
  logic [STG_W-1:0]  in_idx;
  logic [STG_W-1:0]  out_idx;

  always_comb begin
    mask    = stage_mask(stage);
    rd_w    = rd_cnt[ADDR_W-1:0];
    in_idx  = STG_W'(ADDR_W) - stage;
    out_idx = STG_W'(ADDR_W - 1) - stage;

    rd_addr0 = '0;
    rd_addr1 = '0;
    wr_addr0 = '0;
    wr_addr1 = '0;
    tf_addr  = '0;
    in_swap  = 1'b0;
    out_swap = 1'b0;
    bypass_n = 1'b1;

    if (run) begin
      rd_addr0 = rd_w;
      rd_addr1 = rd_w ^ mask;
      wr_addr0 = wr_cnt;
      wr_addr1 = wr_cnt ^ mask;
      tf_addr  = rd_w << stage;
      // Swap selects follow the partner bit; out_swap tracks wr_cnt so it lines up with write-back data.
      in_swap  = (stage != '0) ? rd_cnt[in_idx] : 1'b0;
      out_swap = (stage <= LAST_OSWAP) ? wr_cnt[out_idx] : 1'b0;
      bypass_n = (stage != LAST_STG);
    end
  end
endmodule

// File: rtl/rfft_ctrl.sv
// Stage sequencer for the 4-bank radix-2 256-point FFT: FSM, read counter and stage index.
// Defining RFFT_CTRL_ERR_EN adds start_err, flagging a start that arrives mid-transform.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | sweeping rd_cnt through every stage, writing VALID cycles behind the reads
// DONE  | transform complete; done held until the next start
module rfft_ctrl
  import rfft_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  rfft_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0]  RD_END   = CNT_W'(LIMIT + VALID);
  localparam logic [CNT_W-1:0]  RD_WR0   = CNT_W'(VALID);
  localparam logic [ADDR_W-1:0] WR_LAST  = ADDR_W'(LIMIT);
  localparam logic [STG_W-1:0]  LAST_STG = STG_W'(STAGES - 1);

  rfft_state_e       state_q;
  rfft_state_e       state_d;
  logic [CNT_W-1:0]  rd_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [STG_W-1:0]  stage_q;
  logic              run;
  logic              start_acc;
  logic              we;
  logic              last_wr;

  assign run       = (state_q == RUN);
  assign start_acc = bus.start && !run;
  assign we        = run && (rd_cnt >= RD_WR0);
  assign wr_cnt    = we ? ADDR_W'(rd_cnt - RD_WR0) : '0;
  assign last_wr   = we && (wr_cnt == WR_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_wr && (stage_q == LAST_STG)) state_d = DONE;
      DONE:    if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Stage index is held at the last stage once the transform completes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_cnt  <= '0;
      stage_q <= '0;
    end else if (start_acc) begin
      rd_cnt  <= '0;
      stage_q <= '0;
    end else if (run) begin
      rd_cnt <= (rd_cnt == RD_END) ? '0 : rd_cnt + 1'b1;
      if (last_wr && (stage_q != LAST_STG)) begin
        stage_q <= stage_q + 1'b1;
      end
    end
  end

`ifdef RFFT_CTRL_ERR_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.start_err <= 1'b0;
    end else if (start_acc) begin
      bus.start_err <= 1'b0;
    end else if (bus.start && run) begin
      bus.start_err <= 1'b1;
    end
  end
`endif

  assign bus.we    = we;
  assign bus.stage = stage_q;

  rfft_addr_gen u_addr_gen (
    .run      (run),
    .stage    (stage_q),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt),
    .rd_addr0 (bus.rd_addr0),
    .rd_addr1 (bus.rd_addr1),
    .wr_addr0 (bus.wr_addr0),
    .wr_addr1 (bus.wr_addr1),
    .tf_addr  (bus.tf_addr),
    .in_swap  (bus.in_swap),
    .out_swap (bus.out_swap),
    .bypass_n (bus.bypass_n)
  );
endmodule

// File: tb/tb_rfft_ctrl.sv
// Bench for rfft_ctrl: vector table over the first transform, directed corner sequences,
// then random start/Reset traffic against a cycle-count reference model.
module tb_rfft_ctrl;
  localparam int STAGE_LEN = 66;
  localparam int RUN_LEN   = 462;

  logic Clk = 1'b0;
  logic Reset;

  rfft_ctrl_if bus();

  rfft_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 running, 2 done; m_t = cycles since the run began.
  int m_mode = 0;
  int m_t    = 0;
  bit m_err  = 1'b0;
  bit sb_en  = 1'b0;

  typedef struct {
    int cyc;
    int busy; int done; int we; int stage;
    int rd0; int rd1; int wr0; int wr1; int tf;
    int in_s; int out_s; int byp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_opt(input string name, input int act, input int exp);
    if (exp >= 0) chk(name, act, exp);
  endtask

  task automatic apply_vec(input vec_t v);
    chk_opt($sformatf("c%0d_busy", v.cyc),  int'(bus.busy),     v.busy);
    chk_opt($sformatf("c%0d_done", v.cyc),  int'(bus.done),     v.done);
    chk_opt($sformatf("c%0d_we", v.cyc),    int'(bus.we),       v.we);
    chk_opt($sformatf("c%0d_stage", v.cyc), int'(bus.stage),    v.stage);
    chk_opt($sformatf("c%0d_rd0", v.cyc),   int'(bus.rd_addr0), v.rd0);
    chk_opt($sformatf("c%0d_rd1", v.cyc),   int'(bus.rd_addr1), v.rd1);
    chk_opt($sformatf("c%0d_wr0", v.cyc),   int'(bus.wr_addr0), v.wr0);
    chk_opt($sformatf("c%0d_wr1", v.cyc),   int'(bus.wr_addr1), v.wr1);
    chk_opt($sformatf("c%0d_tf", v.cyc),    int'(bus.tf_addr),  v.tf);
    chk_opt($sformatf("c%0d_in_swap", v.cyc),  int'(bus.in_swap),  v.in_s);
    chk_opt($sformatf("c%0d_out_swap", v.cyc), int'(bus.out_swap), v.out_s);
    chk_opt($sformatf("c%0d_bypass_n", v.cyc), int'(bus.bypass_n), v.byp);
  endtask

  // Called with start already raised for cycle 0; returns the cycle on which done rises.
  task automatic run_until_done(input int pulse_at, output int cyc);
    cyc = -1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge Clk);
      bus.start = (pulse_at > 0) && (c == pulse_at);
      if (c == 1) begin
        chk("busy_rise", int'(bus.busy), 1);
        chk("done_clear", int'(bus.done), 0);
        chk("stage_restart", int'(bus.stage), 0);
      end
`ifdef RFFT_CTRL_ERR_EN
      if ((pulse_at > 0) && (c == pulse_at + 1)) chk("start_err", int'(bus.start_err), 1);
`endif
      if (bus.done === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      m_mode = 0;
      m_t    = 0;
      m_err  = 1'b0;
    end else if (bus.start && (m_mode != 1)) begin
      m_mode = 1;
      m_t    = 0;
      m_err  = 1'b0;
    end else if (m_mode == 1) begin
      if (bus.start) m_err = 1'b1;
      m_t++;
      if (m_t == RUN_LEN) m_mode = 2;
    end
  end

  always @(negedge Clk) begin
    int s, r, w, mask;
    bit run, e_we;
    logic [39:0] act_v, exp_v, care;
    if (sb_en) begin
      run  = (m_mode == 1);
      s    = m_t / STAGE_LEN;
      r    = m_t % STAGE_LEN;
      e_we = run && (r >= 2);
      w    = e_we ? r - 2 : 0;
      mask = 64 - (64 >> s);
      exp_v = '0;
      care  = '1;
      exp_v[39] = run;
      exp_v[38] = (m_mode == 2);
      exp_v[37] = e_we;
      if (run) begin
        exp_v[36:34] = 3'(s);
        exp_v[33:28] = 6'(r % 64);
        exp_v[27:22] = 6'((r % 64) ^ mask);
        exp_v[21:16] = 6'(w);
        exp_v[15:10] = 6'(w ^ mask);
        exp_v[9:4]   = 6'((r << s) % 64);
        exp_v[3]     = (s == 0) ? 1'b0 : 1'((r >> (6 - s)) & 1);
        exp_v[2]     = (s <= 5) ? 1'((w >> (5 - s)) & 1) : 1'b0;
        exp_v[1]     = (s != 6);
        if (r > 63) begin
          care[33:22] = '0;
          care[9:3]   = '0;
        end
      end else begin
        exp_v[1] = 1'b1;
        if (m_mode == 2) begin
          care[36:34] = '0;
          care[1]     = 1'b0;
        end
      end
`ifdef RFFT_CTRL_ERR_EN
      exp_v[0] = m_err;
      act_v = {bus.busy, bus.done, bus.we, bus.stage, bus.rd_addr0, bus.rd_addr1,
               bus.wr_addr0, bus.wr_addr1, bus.tf_addr, bus.in_swap, bus.out_swap,
               bus.bypass_n, bus.start_err};
`else
      exp_v[0] = 1'b0;
      act_v = {bus.busy, bus.done, bus.we, bus.stage, bus.rd_addr0, bus.rd_addr1,
               bus.wr_addr0, bus.wr_addr1, bus.tf_addr, bus.in_swap, bus.out_swap,
               bus.bypass_n, 1'b0};
`endif
      checks++;
      if ((act_v & care) !== (exp_v & care)) begin
        failures++;
        $display("FAIL scoreboard at %0t: got %h expected %h (mode %0d t %0d)",
                 $time, act_v & care, exp_v & care, m_mode, m_t);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    //            cyc  bsy dn we stg rd0 rd1 wr0 wr1 tf  in out byp
    vecs[0] = '{  1,  1, 0, 0, 0,   0,  0,  0,  0,  0, 0, 0,  1};
    vecs[1] = '{  3,  1, 0, 1, 0,   2,  2,  0,  0,  2, 0, 0,  1};
    vecs[2] = '{ 64,  1, 0, 1, 0,  63, 63, 61, 61, 63, 0, 1,  1};
    vecs[3] = '{ 66,  1, 0, 1, 0,  -1, -1, 63, 63, -1,-1, 1,  1};
    vecs[4] = '{ 67,  1, 0, 0, 1,   0, 32,  0, 32,  0, 0, 0,  1};
    vecs[5] = '{ 72,  1, 0, 1, 1,   5, 37,  3, 35, 10, 0, 0,  1};
    vecs[6] = '{183,  1, 0, 1, 2,  50,  2, 48,  0,  8, 1, 0,  1};
    vecs[7] = '{400,  1, 0, 1, 6,   3, 60,  1, 62,  0, 1, 0,  0};
    vecs[8] = '{462,  1, 0, 1, 6,  -1, -1, 63,  0, -1,-1, 0,  0};
    vecs[9] = '{463,  0, 1, 0,-1,   0,  0,  0,  0,  0, 0, 0, -1};

    Reset = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge Clk);
    sb_en = 1'b1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_we", int'(bus.we), 0);
    chk("reset_stage", int'(bus.stage), 0);
    chk("reset_bypass_n", int'(bus.bypass_n), 1);
    Reset = 1'b0;
    @(negedge Clk);

    // First transform, checked against the vector table.
    bus.start = 1'b1;
    for (int c = 1; c <= RUN_LEN + 1; c++) begin
      @(negedge Clk);
      bus.start = 1'b0;
      foreach (vecs[i]) begin
        if (vecs[i].cyc == c) apply_vec(vecs[i]);
      end
    end

    // Start from DONE with a stray start at cycle 100 of the run.
    bus.start = 1'b1;
    run_until_done(100, cyc);
    chk("run2_length", cyc, RUN_LEN + 1);

    // Reset at cycle 200, restart at cycle 210.
    bus.start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge Clk);
      bus.start = 1'b0;
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_we", int'(bus.we), 0);
    chk("midrst_stage", int'(bus.stage), 0);
    chk("midrst_rd_addr1", int'(bus.rd_addr1), 0);
    chk("midrst_bypass_n", int'(bus.bypass_n), 1);
    repeat (9) @(negedge Clk);
    bus.start = 1'b1;
    run_until_done(0, cyc);
    chk("run3_length", cyc, RUN_LEN + 1);

    // start coincident with Reset: Reset wins.
    Reset = 1'b1;
    bus.start = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    bus.start = 1'b0;
    chk("rst_wins_busy", int'(bus.busy), 0);
    chk("rst_wins_done", int'(bus.done), 0);
    @(negedge Clk);
    chk("rst_wins_idle", int'(bus.busy), 0);

    // Random start/Reset traffic, checked by the scoreboard every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge Clk);
      bus.start = ($urandom_range(0, 149) == 0);
      Reset     = ($urandom_range(0, 1999) == 0);
    end
    bus.start = 1'b0;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
